// File: rtl/mul_pkg.sv
// Shared types and sizing for the sequential multiplier and its carry-lookahead adder.
package mul_pkg;

  localparam int unsigned MUL_N = 8;
  localparam int unsigned ADD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } mul_state_t;

endpackage

// File: rtl/cla_add16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a second-level lookahead unit.
module cla_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate and in-group carries, each expanded from the group carry-in
  for (genvar k = 0; k < 4; k++) begin : g_grp
    logic c1;
    logic c2;
    logic c3;

    assign gg[k] = g[4*k+3]
                 | (p[4*k+3] & g[4*k+2])
                 | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                 | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    assign gp[k] = &p[4*k+3:4*k];

    assign c1 = g[4*k] | (p[4*k] & gc[k]);
    assign c2 = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
    assign c3 = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
              | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);

    assign sum[4*k+3:4*k] = p[4*k+3:4*k] ^ {c3, c2, c1, gc[k]};
  end

  // Second-level lookahead: every group carry is derived directly from cin
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  assign cout = gc[4];

endmodule

// File: rtl/seq_mul8_cla.sv
// Sequential NxN unsigned shift-and-add multiplier built around cla_add16.
// Optional SEQ_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module seq_mul8_cla
  import mul_pkg::*;
#(
  parameter int unsigned N = MUL_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned PW    = 2 * N;

  if (PW > ADD_W) begin : g_width_chk
    $error("seq_mul8_cla: 2*N exceeds the adder width");
  end

  mul_state_t        state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [N-1:0]      mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_d;
  logic              done_d;
  logic [PW-1:0]     product_d;

  logic [ADD_W-1:0]  add_a;
  logic [ADD_W-1:0]  add_b;
  logic [ADD_W-1:0]  add_sum;
  logic              add_cout_unused;

  // Partial product plus the multiplicand when the current multiplier bit is set
  assign add_a = ADD_W'(acc_q);
  assign add_b = mplier_q[0] ? ADD_W'(mcand_q) : '0;

  cla_add16 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout_unused)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    product_d = product;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = PW'(a);
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = add_sum[PW-1:0];
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
`ifdef SEQ_MUL_EARLY_EXIT_EN
        if ((cnt_q == CNT_W'(N - 1)) || (mplier_d == '0)) begin
`else
        if (cnt_q == CNT_W'(N - 1)) begin
`endif
          // Result is published on entry to FIN so it is valid alongside done
          state_d   = FIN;
          product_d = acc_d;
          done_d    = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      product  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ready    <= ready_d;
      done     <= done_d;
      product  <= product_d;
    end
  end

endmodule

// File: tb/tb_seq_mul8_cla.sv
// Randomized and directed bench for seq_mul8_cla against an a*b reference with a bit-length latency model.
`timescale 1ns/1ps
module tb_seq_mul8_cla;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ready;
  logic        done;
  logic [15:0] product;

  int          vectors;
  int          miscompares;
  logic [15:0] last_prod;

  seq_mul8_cla dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Edges from the accepting edge (counted as 1) until done is visible
  function automatic int exp_lat(input logic [7:0] bv);
`ifdef SEQ_MUL_EARLY_EXIT_EN
    for (int i = 7; i >= 0; i--)
      if (bv[i]) return i + 2;
    return 2;
`else
    return 9;
`endif
  endfunction

  function automatic logic [31:0] ref_mul(input logic [7:0] av, input logic [7:0] bv);
    return 32'(av) * 32'(bv);
  endfunction

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input bit junk);
    int  lat;
    int  n;
    bit  seen;
    lat = exp_lat(bv);
    n = 0;
    while (!ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_before", 32'(ready), 32'd1);
    a = av;
    b = bv;
    start = 1'b1;
    seen = 1'b0;
    for (int e = 1; e <= 30 && !seen; e++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        check("latency", 32'(e), 32'(lat));
        check("product", 32'(product), ref_mul(av, bv));
      end else begin
        check("hold", 32'(product), 32'(last_prod));
        check("ready_busy", 32'(ready), 32'd0);
        if (junk) begin
          start = 1'($urandom % 2);
          a = 8'($urandom);
          b = 8'($urandom);
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    last_prod = 16'(ref_mul(av, bv));
    @(posedge clk); #1;
    check("ready_after", 32'(ready), 32'd1);
    check("done_pulse", 32'(done), 32'd0);
    check("product_kept", 32'(product), 32'(last_prod));
  endtask

  initial begin
    int lat;
    int prev_e;
    int ndone;

    vectors     = 0;
    miscompares = 0;
    last_prod   = 16'h0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'h0D, 8'h0B, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0);
    run_op(8'h00, 8'hA5, 1'b0);
    run_op(8'h77, 8'h01, 1'b0);
    run_op(8'h5A, 8'h80, 1'b0);
    run_op(8'hC3, 8'h00, 1'b0);
    run_op(8'hFF, 8'h01, 1'b1);

    // start held high: back-to-back operations, one per lat+1 edges
    lat    = exp_lat(8'h05);
    prev_e = 0;
    ndone  = 0;
    a      = 8'h03;
    b      = 8'h05;
    start  = 1'b1;
    for (int e = 1; e <= 3 * (lat + 1); e++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        check("b2b_product", 32'(product), 32'h0F);
        if (prev_e == 0) check("b2b_first", 32'(e), 32'(lat));
        else             check("b2b_interval", 32'(e - prev_e), 32'(lat + 1));
        prev_e = e;
        last_prod = 16'h000F;
      end else begin
        check("b2b_hold", 32'(product), 32'(last_prod));
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(ndone), 32'd3);
    @(posedge clk); #1;

    // Reset in the middle of RUN aborts without a done pulse
    a     = 8'h12;
    b     = 8'h34;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_product", 32'(product), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    rst_n = 1'b1;
    last_prod = 16'h0;
    repeat (12) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_hold", 32'(product), 32'd0);
    end

    for (int i = 0; i < 1000; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom % 2));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
